// File: rtl/video_frame_gate_pkg.sv
// Shared definitions for the video frame gate and its geometry counter.
// The same package is used by the memory read side, so keep it free of
// anything specific to the write path.
package video_frame_gate_pkg;

   localparam int H_PIX_DEF   = 640;
   localparam int V_LINES_DEF = 480;
   localparam int SKIP_W_DEF  = 4;

   localparam int PIX_W  = 11;
   localparam int LINE_W = 10;
   localparam int DATA_W = 24;

   // Gate states: IDLE waits for start-of-frame, PASS forwards, DROP discards.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } gate_state_t;

   // Bit positions inside the sticky status vector.
   localparam int STAT_ERR_SHORT = 0;
   localparam int STAT_ERR_LONG  = 1;
   localparam int STAT_ERR_SOF   = 2;
   localparam int STAT_W         = 3;

endpackage

// File: rtl/video_frame_gate_geom.sv
// Pixel/line position tracker with geometry checking against tlast and tuser.
// A beat carrying tuser always becomes pixel 0 of line 0, so an early start-of-
// frame restarts the counters on that very beat. eof and the *_det strobes are
// combinational and only valid while count_en is high.
module video_geom_counter
   import video_frame_gate_pkg::*;
#(
   parameter int H_PIX   = H_PIX_DEF,
   parameter int V_LINES = V_LINES_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              count_en,
   input  logic              in_frame,
   input  logic              tuser,
   input  logic              tlast,
   output logic [PIX_W-1:0]  pix_cnt,
   output logic [LINE_W-1:0] line_cnt,
   output logic              eof,
   output logic              short_det,
   output logic              long_det,
   output logic              sof_det
);

   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_PIX - 1);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);

   logic [PIX_W-1:0]  pix_q, pix_d, pix_eff;
   logic [LINE_W-1:0] line_q, line_d, line_eff;

   // Next-position and geometry error detection for the current beat.
   always_comb begin
      pix_eff   = tuser ? '0 : pix_q;
      line_eff  = tuser ? '0 : line_q;
      pix_d     = pix_q;
      line_d    = line_q;
      eof       = 1'b0;
      short_det = 1'b0;
      long_det  = 1'b0;
      sof_det   = 1'b0;
      if (count_en) begin
         sof_det = tuser & in_frame & ((pix_q != '0) | (line_q != '0));
         if (tlast) begin
            short_det = (pix_eff < PIX_LAST);
            pix_d     = '0;
            if (line_eff == LINE_LAST) begin
               eof    = 1'b1;
               line_d = '0;
            end else begin
               line_d = line_eff + LINE_W'(1);
            end
         end else if (pix_eff == PIX_LAST) begin
            long_det = 1'b1;
            pix_d    = pix_eff;
            line_d   = line_eff;
         end else begin
            pix_d  = pix_eff + PIX_W'(1);
            line_d = line_eff;
         end
      end
   end

   // Position registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pix_q  <= '0;
         line_q <= '0;
      end else begin
         pix_q  <= pix_d;
         line_q <= line_d;
      end
   end

   assign pix_cnt  = pix_q;
   assign line_cnt = line_q;

endmodule

// File: rtl/video_frame_gate.sv
// Frame gate between the colour-space converter stream and the frame memory
// writer. Aligns to tuser, forwards 1 of every frame_skip+1 frames, and keeps
// sticky geometry error flags. The datapath is combinational; the start-of-
// frame beat seen in IDLE is already forwarded when that frame is to be passed,
// so s_tready follows m_tready for it as well.
module video_frame_gate
   import video_frame_gate_pkg::*;
#(
   parameter int H_PIX   = H_PIX_DEF,
   parameter int V_LINES = V_LINES_DEF,
   parameter int SKIP_W  = SKIP_W_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   input  logic [SKIP_W-1:0] frame_skip,
   input  logic              err_clr,
   input  logic [DATA_W-1:0] s_axis_video_tdata,
   input  logic              s_axis_video_tvalid,
   output logic              s_axis_video_tready,
   input  logic              s_axis_video_tuser,
   input  logic              s_axis_video_tlast,
   output logic [DATA_W-1:0] m_axis_video_tdata,
   output logic              m_axis_video_tvalid,
   input  logic              m_axis_video_tready,
   output logic              m_axis_video_tuser,
   output logic              m_axis_video_tlast,
   output logic              frame_done,
   output logic [15:0]       frame_cnt,
   output logic [LINE_W-1:0] line_cnt,
   output logic [PIX_W-1:0]  pix_cnt,
   output logic              err_short,
   output logic              err_long,
   output logic              err_sof
);

   gate_state_t       state_q, state_d;
   logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic              frame_done_q, frame_done_d;
   logic [STAT_W-1:0] err_q, err_d, err_new;

   logic in_frame, start, pass_now, beat, count_en;
   logic eof, short_det, long_det, sof_det;

   assign in_frame = (state_q != ST_IDLE);
   assign start    = (state_q == ST_IDLE) & s_axis_video_tuser & enable;
   assign pass_now = (state_q == ST_PASS) | (start & (skip_cnt_q == '0));

   assign s_axis_video_tready = pass_now ? m_axis_video_tready : 1'b1;
   assign m_axis_video_tvalid = s_axis_video_tvalid & pass_now;
   assign m_axis_video_tdata  = s_axis_video_tdata;
   assign m_axis_video_tuser  = s_axis_video_tuser;
   assign m_axis_video_tlast  = s_axis_video_tlast;

   assign beat     = s_axis_video_tvalid & s_axis_video_tready;
   assign count_en = beat & (in_frame | start);

   video_geom_counter #(
      .H_PIX   (H_PIX),
      .V_LINES (V_LINES)
   ) u_geom (
      .clk       (clk),
      .rstn      (rstn),
      .count_en  (count_en),
      .in_frame  (in_frame),
      .tuser     (s_axis_video_tuser),
      .tlast     (s_axis_video_tlast),
      .pix_cnt   (pix_cnt),
      .line_cnt  (line_cnt),
      .eof       (eof),
      .short_det (short_det),
      .long_det  (long_det),
      .sof_det   (sof_det)
   );

   // Frame state, skip decimation and passed-frame bookkeeping.
   always_comb begin
      state_d      = state_q;
      skip_cnt_d   = skip_cnt_q;
      frame_cnt_d  = frame_cnt_q;
      frame_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count_en) begin
               state_d = (skip_cnt_q == '0) ? ST_PASS : ST_DROP;
            end
         end
         ST_PASS, ST_DROP: state_d = state_q;
         default:          state_d = ST_IDLE;
      endcase
      if (eof) begin
         state_d      = ST_IDLE;
         frame_done_d = pass_now;
         if (pass_now) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
         end
         skip_cnt_d = (skip_cnt_q == frame_skip) ? '0 : skip_cnt_q + SKIP_W'(1);
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps its flag set.
   always_comb begin
      err_new                 = '0;
      err_new[STAT_ERR_SHORT] = short_det;
      err_new[STAT_ERR_LONG]  = long_det;
      err_new[STAT_ERR_SOF]   = sof_det;
      err_d                   = (err_q & ~{STAT_W{err_clr}}) | err_new;
   end

   // State and status registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         skip_cnt_q   <= '0;
         frame_cnt_q  <= '0;
         frame_done_q <= 1'b0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         skip_cnt_q   <= skip_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;
   assign err_short  = err_q[STAT_ERR_SHORT];
   assign err_long   = err_q[STAT_ERR_LONG];
   assign err_sof    = err_q[STAT_ERR_SOF];

endmodule

// File: tb/tb_video_frame_gate.sv
// Directed-sequence bench for video_frame_gate with randomized data, gaps and
// back-pressure, checked beat by beat against a frame-level reference model.
module tb_video_frame_gate;

   localparam int H  = 16;
   localparam int V  = 4;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          enable = 1'b0;
   logic [SW-1:0] frame_skip = '0;
   logic          err_clr = 1'b0;
   logic [23:0]   s_tdata = '0;
   logic          s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
   logic          s_tready;
   logic [23:0]   m_tdata;
   logic          m_tvalid, m_tuser, m_tlast;
   logic          m_tready = 1'b1;
   logic          frame_done;
   logic [15:0]   frame_cnt;
   logic [9:0]    line_cnt;
   logic [10:0]   pix_cnt;
   logic          err_short, err_long, err_sof;

   video_frame_gate #(.H_PIX(H), .V_LINES(V), .SKIP_W(SW)) dut (
      .clk                 (clk),
      .rstn                (rstn),
      .enable              (enable),
      .frame_skip          (frame_skip),
      .err_clr             (err_clr),
      .s_axis_video_tdata  (s_tdata),
      .s_axis_video_tvalid (s_tvalid),
      .s_axis_video_tready (s_tready),
      .s_axis_video_tuser  (s_tuser),
      .s_axis_video_tlast  (s_tlast),
      .m_axis_video_tdata  (m_tdata),
      .m_axis_video_tvalid (m_tvalid),
      .m_axis_video_tready (m_tready),
      .m_axis_video_tuser  (m_tuser),
      .m_axis_video_tlast  (m_tlast),
      .frame_done          (frame_done),
      .frame_cnt           (frame_cnt),
      .line_cnt            (line_cnt),
      .pix_cnt             (pix_cnt),
      .err_short           (err_short),
      .err_long            (err_long),
      .err_sof             (err_sof)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fwd       = 0;
   int p_ready   = 100;

   // Reference model state: frame-level view of the stream.
   bit m_in_frame = 0, m_pass = 0, m_done = 0;
   int m_pix = 0, m_line = 0, m_since = 0, m_fcnt = 0;
   bit e_short = 0, e_long = 0, e_sof = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic modelReset();
      m_in_frame = 0; m_pass = 0; m_done = 0;
      m_pix = 0; m_line = 0; m_since = 0; m_fcnt = 0;
      e_short = 0; e_long = 0; e_sof = 0;
   endtask

   task automatic modelBeat(input bit acc, input bit u, input bit l, input bit clr);
      bit start, sh, lg, sf;
      sh = 0; lg = 0; sf = 0;
      m_done = 0;
      start = acc && !m_in_frame && u && enable;
      if (acc && (m_in_frame || start)) begin
         if (start) begin
            m_in_frame = 1;
            m_pass = (m_since == 0);
         end else if (u) begin
            sf = (m_pix != 0 || m_line != 0);
         end
         if (u) begin
            m_pix = 0;
            m_line = 0;
         end
         if (l) begin
            sh = (m_pix < H - 1);
            m_pix = 0;
            m_line++;
            if (m_line == V) begin
               m_done = m_pass;
               if (m_pass) m_fcnt = (m_fcnt + 1) % 65536;
               m_since = (m_since == int'(frame_skip)) ? 0 : m_since + 1;
               m_in_frame = 0;
               m_line = 0;
            end
         end else if (m_pix == H - 1) begin
            lg = 1;
         end else begin
            m_pix++;
         end
      end
      e_short = (e_short && !clr) || sh;
      e_long  = (e_long && !clr) || lg;
      e_sof   = (e_sof && !clr) || sf;
   endtask

   // One clock cycle: drive, check the combinational path, then check state.
   task automatic applyStimulus(input bit v, input logic [23:0] d, input bit u, input bit l,
                                input bit mr, input bit clr, output bit acc);
      bit pn, exp_rdy;
      @(negedge clk);
      s_tvalid = v; s_tdata = d; s_tuser = u; s_tlast = l; m_tready = mr; err_clr = clr;
      #1;
      pn = m_in_frame ? m_pass : (u && enable && m_since == 0);
      exp_rdy = pn ? mr : 1'b1;
      checkOutput("s_tready", s_tready, exp_rdy);
      checkOutput("m_tvalid", m_tvalid, v & pn);
      if (v && pn) begin
         checkOutput("m_tdata", m_tdata, d);
         checkOutput("m_tuser_tlast", {m_tuser, m_tlast}, {u, l});
      end
      if (m_tvalid === 1'b1 && mr) fwd++;
      acc = v & exp_rdy;
      @(posedge clk);
      #1;
      modelBeat(acc, u, l, clr);
      checkOutput("pix_cnt", pix_cnt, m_pix);
      checkOutput("line_cnt", line_cnt, m_line);
      checkOutput("frame_cnt", frame_cnt, m_fcnt);
      checkOutput("frame_done", frame_done, m_done);
      checkOutput("errs", {err_short, err_long, err_sof}, {e_short, e_long, e_sof});
   endtask

   task automatic sendBeat(input bit u, input bit l, input bit clr);
      bit acc;
      int tries;
      logic [23:0] d;
      d = 24'($urandom);
      if ($urandom_range(0, 7) == 0) applyStimulus(0, 24'($urandom), 0, 0, 1, 0, acc);
      acc = 0;
      tries = 0;
      while (!acc && tries < 64) begin
         applyStimulus(1, d, u, l, ($urandom_range(1, 100) <= p_ready), clr, acc);
         tries++;
      end
      if (!acc) checkOutput("beat_timeout", 0, 1);
   endtask

   task automatic sendLine(input int n, input bit sof);
      for (int p = 0; p < n; p++) sendBeat(sof && p == 0, p == n - 1, 0);
   endtask

   task automatic sendFrame(input int l0, input int l1, input int l2, input int l3);
      int lens[4];
      lens = '{l0, l1, l2, l3};
      for (int ln = 0; ln < V; ln++) sendLine(lens[ln], ln == 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit acc;
      // Reset state
      #23;
      checkOutput("rst_frame_cnt", frame_cnt, 0);
      checkOutput("rst_pos", {line_cnt, pix_cnt}, 0);
      checkOutput("rst_status", {frame_done, err_short, err_long, err_sof, m_tvalid}, 0);
      @(negedge clk);
      rstn = 1'b1;
      enable = 1'b1;

      // 1: three clean frames, no skipping
      $display("[TB] step 1: clean frames");
      frame_skip = 0; fwd = 0;
      for (int f = 0; f < 3; f++) sendFrame(H, H, H, H);
      checkOutput("t1_forwarded", fwd, 3 * H * V);
      checkOutput("t1_frame_cnt", frame_cnt, 3);
      checkOutput("t1_errs", {err_short, err_long, err_sof}, 0);

      // 2: frame_skip=2 passes frames 0 and 3 of six
      $display("[TB] step 2: decimation");
      frame_skip = 2; fwd = 0;
      for (int f = 0; f < 6; f++) sendFrame(H, H, H, H);
      checkOutput("t2_forwarded", fwd, 2 * H * V);
      checkOutput("t2_frame_cnt", frame_cnt, 5);
      frame_skip = 0;

      // 3: random back-pressure, no loss
      $display("[TB] step 3: back-pressure");
      p_ready = 50; fwd = 0;
      for (int f = 0; f < 2; f++) sendFrame(H, H, H, H);
      checkOutput("t3_forwarded", fwd, 2 * H * V);
      checkOutput("t3_frame_cnt", frame_cnt, 7);
      p_ready = 100;

      // enable dropped mid-frame: frame completes, the next one is not taken
      $display("[TB] step 3b: enable deassert");
      fwd = 0;
      sendLine(H, 1);
      enable = 1'b0;
      for (int ln = 1; ln < V; ln++) sendLine(H, 0);
      sendFrame(H, H, H, H);
      checkOutput("t3b_forwarded", fwd, H * V);
      checkOutput("t3b_frame_cnt", frame_cnt, 8);
      enable = 1'b1;

      // 4: short then long line, clear, then error racing the clear
      $display("[TB] step 4: geometry errors");
      sendFrame(H, 12, 20, H);
      checkOutput("t4_short_long", {err_short, err_long}, 2'b11);
      applyStimulus(0, 0, 0, 0, 1, 1, acc);
      checkOutput("t4_cleared", {err_short, err_long, err_sof}, 0);
      sendBeat(1, 0, 0);
      sendBeat(0, 0, 0);
      sendBeat(0, 1, 1);
      checkOutput("t4_error_wins", err_short, 1);
      for (int ln = 1; ln < V; ln++) sendLine(H, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, acc);

      // 5: early start-of-frame at line 2 pixel 5
      $display("[TB] step 5: early SOF");
      sendLine(H, 1);
      sendLine(H, 0);
      for (int p = 0; p < 5; p++) sendBeat(0, 0, 0);
      sendBeat(1, 0, 0);
      checkOutput("t5_sof", err_sof, 1);
      checkOutput("t5_pos", {line_cnt, pix_cnt}, {10'd0, 11'd1});
      checkOutput("t5_no_done", frame_done, 0);
      sendBeat(0, 0, 0);
      for (int p = 2; p < H; p++) sendBeat(0, p == H - 1, 0);
      for (int ln = 1; ln < V; ln++) sendLine(H, 0);

      // 6: asynchronous reset in the middle of a frame
      $display("[TB] step 6: mid-frame reset");
      sendLine(H, 1);
      for (int p = 0; p < 3; p++) sendBeat(0, 0, 0);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      modelReset();
      checkOutput("t6_rst_counts", {frame_cnt, line_cnt, pix_cnt}, 0);
      checkOutput("t6_rst_status", {frame_done, err_short, err_long, err_sof}, 0);
      @(negedge clk);
      rstn = 1'b1;
      fwd = 0;
      for (int p = 0; p < 10; p++) sendBeat(0, p == 9, 0);
      checkOutput("t6_dropped", fwd, 0);
      sendFrame(H, H, H, H);
      checkOutput("t6_forwarded", fwd, H * V);
      checkOutput("t6_frame_cnt", frame_cnt, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
